// File: rtl/req_pri_arbiter.sv
// Registered N-way arbiter: highest-index-wins priority, grant hold, one-cycle
// turnaround gap and MAX_HOLD timeout. Define REQ_PRI_ARBITER_RR_EN for round-robin search.
module req_pri_arbiter #(
    parameter int N        = 8,
    parameter int ID_W     = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HC_MAX = HC_W'((MAX_HOLD > 0) ? MAX_HOLD : 1);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [ID_W-1:0] r_gnt_id;
    logic            r_timeout;
    logic [HC_W-1:0] r_hold_cnt;
    logic [ID_W-1:0] r_last_id;

    state_t          w_next_state;
    logic [N-1:0]    w_next_gnt;
    logic [ID_W-1:0] w_next_gnt_id;
    logic            w_next_timeout;
    logic [HC_W-1:0] w_next_hold_cnt;
    logic [ID_W-1:0] w_next_last_id;
    logic [ID_W-1:0] w_win_id;

`ifdef REQ_PRI_ARBITER_RR_EN
    // Search last_id-1, last_id-2, ... (mod N); the last assignment in the loop wins,
    // so iterate from the lowest-priority candidate (last_id itself) upward.
    always_comb begin
        w_win_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(r_last_id) + 2 * N - 1 - k) % N]) begin
                w_win_id = ID_W'((int'(r_last_id) + 2 * N - 1 - k) % N);
            end
        end
    end
`else
    logic w_unused_last_id;
    assign w_unused_last_id = ^r_last_id;

    always_comb begin
        w_win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_next_state    = r_state;
        w_next_gnt      = r_gnt;
        w_next_gnt_id   = r_gnt_id;
        w_next_timeout  = 1'b0;
        w_next_hold_cnt = r_hold_cnt;
        w_next_last_id  = r_last_id;

        case (r_state)
            IDLE, GAP: begin
                if (|req) begin
                    w_next_state    = GRANT;
                    w_next_gnt      = ONE_HOT0 << w_win_id;
                    w_next_gnt_id   = w_win_id;
                    w_next_hold_cnt = HC_W'(1);
                    w_next_last_id  = w_win_id;
                end else begin
                    w_next_state    = IDLE;
                    w_next_gnt      = '0;
                end
            end
            GRANT: begin
                if (!req[r_gnt_id]) begin
                    w_next_state    = GAP;
                    w_next_gnt      = '0;
                    w_next_hold_cnt = '0;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == HC_MAX)) begin
                    w_next_state    = GAP;
                    w_next_gnt      = '0;
                    w_next_hold_cnt = '0;
                    w_next_timeout  = 1'b1;
                end else if (r_hold_cnt < HC_MAX) begin
                    w_next_hold_cnt = r_hold_cnt + HC_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_gnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
            r_last_id  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_gnt      <= w_next_gnt;
            r_gnt_id   <= w_next_gnt_id;
            r_timeout  <= w_next_timeout;
            r_hold_cnt <= w_next_hold_cnt;
            r_last_id  <= w_next_last_id;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_pri_arbiter.sv
// Scoreboard bench for req_pri_arbiter (N=8, MAX_HOLD=4): directed scenarios then random
// request patterns, checked against a grant-ownership model of the arbitration rules.
module tb_req_pri_arbiter;

    localparam int N    = 8;
    localparam int MAXH = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         gnt_valid;
    logic         timeout;

    typedef struct {
        logic [N-1:0] gnt;
        logic [2:0]   id;
        logic         valid;
        logic         to;
        int           cyc;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    int   cycleNo = 0;

    // Model state: who owns the resource (-1 = nobody), for how long, and who won last.
    int   mOwner = -1;
    int   mHeld  = 0;
    int   mLast  = 0;
    int   mId    = 0;
    logic mTo    = 1'b0;

    req_pri_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pickWinner(input logic [N-1:0] r, input int last);
        int w;
        w = -1;
`ifdef REQ_PRI_ARBITER_RR_EN
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (((last - k) % N) + N) % N;
            if (w < 0 && r[idx]) w = idx;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (w < 0 && r[i]) w = i;
        end
`endif
        return w;
    endfunction

    // Advance the model by one clock edge with the inputs that edge will sample.
    task automatic modelStep(input logic r, input logic [N-1:0] q);
        exp_t e;
        mTo = 1'b0;
        if (r) begin
            mOwner = -1; mHeld = 0; mLast = 0; mId = 0;
        end else if (mOwner >= 0) begin
            if (!q[mOwner]) begin
                mOwner = -1;
            end else if (mHeld == MAXH) begin
                mOwner = -1;
                mTo    = 1'b1;
            end else begin
                mHeld++;
            end
        end else if (q != 0) begin
            mOwner = pickWinner(q, mLast);
            mHeld  = 1;
            mLast  = mOwner;
            mId    = mOwner;
        end
        e.gnt   = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
        e.id    = 3'(mId);
        e.valid = (mOwner >= 0);
        e.to    = mTo;
        e.cyc   = cycleNo;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] q, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rst = r;
            req = q;
            modelStep(r, q);
            @(posedge clk);
            #2;
            cycleNo++;
        end
    endtask

    task automatic checkOutput(input string name, input int cyc, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    // Monitor: mid-cycle, compare the DUT outputs against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("gnt",       e.cyc, int'(gnt),       int'(e.gnt));
                checkOutput("gnt_id",    e.cyc, int'(gnt_id),    int'(e.id));
                checkOutput("gnt_valid", e.cyc, int'(gnt_valid), int'(e.valid));
                checkOutput("timeout",   e.cyc, int'(timeout),   int'(e.to));
                checkOutput("onehot0",   e.cyc, int'($onehot0(gnt)), 1);
                checkOutput("to_excl",   e.cyc, int'(timeout & gnt_valid), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic         r;
        logic [N-1:0] q;
        int           len;
        rst = 1'b1;
        req = '0;

        applyStimulus(1'b1, 8'hFF, 3);
        applyStimulus(1'b0, 8'hFF, 3);

        applyStimulus(1'b1, 8'h00, 1);
        applyStimulus(1'b0, 8'h28, 4);
        applyStimulus(1'b0, 8'h08, 4);
        applyStimulus(1'b0, 8'h00, 2);

        applyStimulus(1'b0, 8'h02, 3);
        applyStimulus(1'b0, 8'h42, 3);
        applyStimulus(1'b0, 8'h40, 4);
        applyStimulus(1'b0, 8'h00, 2);

        applyStimulus(1'b0, 8'h01, 15);
        applyStimulus(1'b0, 8'h00, 2);

        applyStimulus(1'b1, 8'h00, 1);
        applyStimulus(1'b0, 8'h81, 20);
        applyStimulus(1'b0, 8'h00, 2);

        applyStimulus(1'b0, 8'h10, 2);
        applyStimulus(1'b1, 8'h10, 1);
        applyStimulus(1'b0, 8'h10, 8);
        applyStimulus(1'b0, 8'h00, 2);

        for (int s = 0; s < 50; s++) begin
            len = $urandom_range(1, 8);
            q   = (s % 2 == 0) ? N'($urandom) : N'($urandom & $urandom);
            r   = ($urandom_range(0, 29) == 0);
            applyStimulus(r, q, len);
        end
        applyStimulus(1'b0, 8'h00, 2);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", cycleNo, expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
